// File: rtl/vc_input_buffer.sv
// Two-VC input FIFO: per-VC queues, head of VC[polarity] presented as rq/do_dat, popped on gt.
// Latency: push visible next cycle (no bypass); ri decoded from registered pointers only, so backpressure lags a pop by one cycle.
// Optional sticky overflow detector enabled by `VC_INPUT_BUFFER_OVF_CHECK_EN.
module vc_input_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  si,
    input  logic [DATA_WIDTH-1:0] di,
    output logic [1:0]            ri,
    output logic                  rq,
    input  logic                  gt,
    output logic [DATA_WIDTH-1:0] do_dat,
    output logic                  ovf_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [0:1][0:DEPTH-1];
    logic [PW-1:0]         wptr [0:1];
    logic [PW-1:0]         rptr [0:1];
    logic [1:0]            full;
    logic [1:0]            empty;
    logic                  push_vc;
    logic                  push;
    logic                  pop;

    assign push_vc = di[DATA_WIDTH-1];
    assign push    = si && !full[push_vc];
    assign pop     = gt && rq;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        localparam logic VCB = 1'(v);

        // Full: same slot, opposite lap (wrap bits differ).
        assign empty[v] = (wptr[v] == rptr[v]);
        assign full[v]  = (wptr[v][AW-1:0] == rptr[v][AW-1:0]) && (wptr[v][AW] != rptr[v][AW]);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
            end else begin
                if (push && (push_vc == VCB))
                    wptr[v] <= wptr[v] + 1'b1;
                if (pop && (polarity == VCB))
                    rptr[v] <= rptr[v] + 1'b1;
            end
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[push_vc][wptr[push_vc][AW-1:0]] <= di;
    end

    assign ri     = ~full;
    assign rq     = !empty[polarity];
    assign do_dat = empty[polarity] ? '0 : mem[polarity][rptr[polarity][AW-1:0]];

`ifdef VC_INPUT_BUFFER_OVF_CHECK_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (si && full[push_vc])
            ovf_q <= 1'b1;
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

endmodule
